vectrex_cart_loader: RTL and testbench



---
 rtl/vectrex_cart_loader.sv | 121 ++++++++++++
 tb/tb_vectrex_cart_loader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/vectrex_cart_loader.sv
// vectrex_cart_loader: streams HPS ioctl bytes into cartridge RAM with back-pressure,
// tracking the power-of-two address mask, loaded size and the "g GCE" header.
module vectrex_cart_loader #(
    parameter int ADDR_W  = 15,
    parameter int HDR_LEN = 5
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_data,
    output logic              ram_req,
    input  logic              ram_ack,
    output logic [ADDR_W-1:0] cart_mask,
    output logic [ADDR_W:0]   cart_size,
    output logic              header_ok,
    output logic              overflow,
    output logic              busy,
    output logic              load_done
);
    typedef enum logic [1:0] {IDLE, LOAD, WRITE, FINISH} state_t;

    state_t            state;
    logic              dl_q;
    logic              hdr_match;
    logic              skid_v;
    logic [ADDR_W-1:0] skid_addr;
    logic [7:0]        skid_data;
    logic [ADDR_W-1:0] a;
    logic              in_range;
    logic              active;
    logic              accept;

    function automatic logic [7:0] sig_byte(input logic [ADDR_W-1:0] i);
        return i == 0 ? 8'h67 : i == 1 ? 8'h20 : i == 2 ? 8'h47 : i == 3 ? 8'h43 : 8'h45;
    endfunction

    assign a         = ioctl_addr[ADDR_W-1:0];
    assign in_range  = ioctl_addr[24:ADDR_W] == '0;
    assign active    = state == LOAD || state == WRITE;
    assign accept    = ioctl_wr && in_range && active;
    assign busy      = state != IDLE;
    assign load_done = state == FINISH;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state      <= IDLE;
            dl_q       <= 1'b0;
            ram_req    <= 1'b0;
            ioctl_wait <= 1'b0;
            ram_addr   <= '0;
            ram_data   <= '0;
            cart_mask  <= '0;
            cart_size  <= '0;
            header_ok  <= 1'b0;
            overflow   <= 1'b0;
            hdr_match  <= 1'b0;
            skid_v     <= 1'b0;
            skid_addr  <= '0;
            skid_data  <= '0;
        end else begin
            dl_q <= ioctl_download;
            // bookkeeping happens when a byte is taken, whether it goes straight out or into the skid slot
            if (accept) begin
                if ((a & ~cart_mask) != '0)
                    cart_mask <= {cart_mask[ADDR_W-2:0], 1'b1};
                if ({1'b0, a} >= cart_size)
                    cart_size <= {1'b0, a} + 1'b1;
                if (a < ADDR_W'(HDR_LEN) && ioctl_dout != sig_byte(a))
                    hdr_match <= 1'b0;
            end
            if (ioctl_wr && !in_range && active)
                overflow <= 1'b1;
            case (state)
                IDLE: if (ioctl_download && !dl_q) begin
                    cart_mask <= '0;
                    cart_size <= '0;
                    overflow  <= 1'b0;
                    hdr_match <= 1'b1;
                    state     <= LOAD;
                end
                LOAD: if (accept) begin
                    ram_addr   <= a;
                    ram_data   <= ioctl_dout;
                    ram_req    <= 1'b1;
                    ioctl_wait <= 1'b1;
                    state      <= WRITE;
                end else if (!ioctl_download) begin
                    state <= FINISH;
                end
                WRITE: begin
                    if (accept) begin
                        skid_v    <= 1'b1;
                        skid_addr <= a;
                        skid_data <= ioctl_dout;
                    end
                    if (ram_ack) begin
                        if (skid_v) begin
                            ram_addr <= skid_addr;
                            ram_data <= skid_data;
                            skid_v   <= 1'b0;
                        end else begin
                            ram_req    <= 1'b0;
                            ioctl_wait <= 1'b0;
                            state      <= ioctl_download ? LOAD : FINISH;
                        end
                    end
                end
                FINISH: begin
                    header_ok <= hdr_match && cart_size >= (ADDR_W+1)'(HDR_LEN);
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vectrex_cart_loader.sv
// tb_vectrex_cart_loader: directed loads against a cartridge RAM model that acks 3 cycles after each request.
module tb_vectrex_cart_loader;
    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        ram_ack = 1'b0;
    logic        ioctl_wait, ram_req, header_ok, overflow, busy, load_done;
    logic [14:0] ram_addr, cart_mask;
    logic [7:0]  ram_data;
    logic [15:0] cart_size;

    int checks = 0, failures = 0;
    int writes = 0, done_cnt = 0, cyc = 0, ack_cyc = 0, done_cyc = 0, cnt = 0;
    int w0;
    logic [7:0]  mem [32768];
    logic [14:0] last_addr = '0;

    vectrex_cart_loader dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wait(ioctl_wait), .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_req(ram_req), .ram_ack(ram_ack), .cart_mask(cart_mask),
        .cart_size(cart_size), .header_ok(header_ok), .overflow(overflow),
        .busy(busy), .load_done(load_done)
    );

    always #5 clk_sys = ~clk_sys;

    // cartridge RAM: ack on the third cycle a request has been held
    always @(negedge clk_sys) begin
        cyc++;
        ram_ack = 1'b0;
        if (!ram_req) cnt = 0;
        else begin
            cnt++;
            if (cnt == 3) begin
                ram_ack = 1'b1;
                cnt = 0;
                mem[ram_addr] = ram_data;
                last_addr = ram_addr;
                writes++;
                ack_cyc = cyc;
            end
        end
        if (load_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] img(input int a);
        return a == 0 ? 8'h67 : a == 1 ? 8'h20 : a == 2 ? 8'h47 : a == 3 ? 8'h43 :
               a == 4 ? 8'h45 : 8'(a) ^ 8'hA5;
    endfunction

    task automatic send(input int a, input logic [7:0] d);
        int t;
        t = 0;
        while (ioctl_wait && t < 100) begin
            @(negedge clk_sys);
            t++;
        end
        if (t >= 100) chk("wait_timeout", 32'(t), 32'd0);
        ioctl_addr = 25'(a);
        ioctl_dout = d;
        ioctl_wr = 1'b1;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
    endtask

    task automatic dl_start();
        ioctl_download = 1'b1;
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic dl_end();
        int t, d0;
        t = 0;
        d0 = done_cnt;
        ioctl_download = 1'b0;
        while (done_cnt == d0 && t < 200) begin
            @(negedge clk_sys);
            t++;
        end
        if (t >= 200) chk("done_timeout", 32'(t), 32'd0);
        repeat (3) @(negedge clk_sys);
        chk("done_pulses", 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic load_seq(input int n, input logic [7:0] b2);
        dl_start();
        for (int i = 0; i < n; i++) send(i, i == 2 ? b2 : img(i));
        dl_end();
    endtask

    initial begin
        repeat (3) @(negedge clk_sys);
        chk("rst_req", ram_req, 0);
        chk("rst_wait", ioctl_wait, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", load_done, 0);
        reset_n = 1'b1;
        @(negedge clk_sys);
        chk("rst_mask", cart_mask, 0);
        chk("rst_size", cart_size, 0);
        chk("rst_hdr", header_ok, 0);
        chk("rst_ovf", overflow, 0);

        w0 = writes;
        load_seq(8192, 8'h47);
        chk("8k_writes", 32'(writes - w0), 8192);
        chk("8k_mask", cart_mask, 15'h1FFF);
        chk("8k_size", cart_size, 16'h2000);
        chk("8k_hdr", header_ok, 1);
        chk("8k_ovf", overflow, 0);
        chk("8k_busy", busy, 0);
        chk("8k_mem2", mem[2], 8'h47);
        chk("8k_mem1234", mem[15'h1234], img(32'h1234));
        chk("8k_memlast", mem[15'h1FFF], img(32'h1FFF));

        load_seq(4097, 8'h47);
        chk("4097_mask", cart_mask, 15'h1FFF);
        chk("4097_size", cart_size, 16'h1001);
        chk("4097_hdr", header_ok, 1);

        w0 = writes;
        dl_start();
        for (int i = 0; i < 5; i++) send(i, img(i));
        for (int k = 3; k < 15; k++) send(1 << k, img(1 << k));
        send(32'h7FFF, img(32'h7FFF));
        for (int i = 0; i < 16; i++) send(32'h8000 + i, 8'hEE);
        dl_end();
        chk("ovf_writes", 32'(writes - w0), 18);
        chk("ovf_mask", cart_mask, 15'h7FFF);
        chk("ovf_size", cart_size, 16'h8000);
        chk("ovf_flag", overflow, 1);
        chk("ovf_hdr", header_ok, 1);
        chk("ovf_memtop", mem[15'h7FFF], img(32'h7FFF));
        chk("ovf_noalias", mem[3], 8'h43);

        load_seq(8, 8'h48);
        chk("bad_hdr", header_ok, 0);
        chk("bad_size", cart_size, 8);
        chk("bad_mask", cart_mask, 7);

        load_seq(3, 8'h47);
        chk("short_hdr", header_ok, 0);
        chk("short_size", cart_size, 3);
        chk("short_mask", cart_mask, 3);

        w0 = writes;
        dl_start();
        ioctl_addr = 25'd0;
        ioctl_dout = 8'h11;
        ioctl_wr = 1'b1;
        @(negedge clk_sys);
        ioctl_addr = 25'd1;
        ioctl_dout = 8'h22;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        dl_end();
        chk("skid_writes", 32'(writes - w0), 2);
        chk("skid_last", last_addr, 1);
        chk("skid_mem0", mem[0], 8'h11);
        chk("skid_mem1", mem[1], 8'h22);
        chk("skid_size", cart_size, 2);
        chk("skid_order", done_cyc > ack_cyc, 1);

        dl_start();
        ioctl_addr = 25'd0;
        ioctl_dout = 8'h67;
        ioctl_wr = 1'b1;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        chk("mid_req", ram_req, 1);
        reset_n = 1'b0;
        @(negedge clk_sys);
        chk("mid_rst_req", ram_req, 0);
        chk("mid_rst_wait", ioctl_wait, 0);
        chk("mid_rst_busy", busy, 0);
        reset_n = 1'b1;
        ioctl_download = 1'b0;
        repeat (2) @(negedge clk_sys);
        dl_start();
        chk("new_mask", cart_mask, 0);
        chk("new_busy", busy, 1);
        send(0, 8'h67);
        send(1, 8'h20);
        dl_end();
        chk("new_mask2", cart_mask, 1);
        chk("new_size", cart_size, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
